mem_lsu: RTL and testbench

Load/store unit sitting directly upstream of the word-addressed data RAM (1024 × 32-bit, combinational read when RE=1, write on rising clk when WE=1). Accepts byte-addressed RISC-V load/store requests from the execute/memory stage. Converts them to word accesses, sign/zero-extends sub-word loads, and performs read-modify-write for SB/SH because the RAM has no byte enables. Misaligned or out-of-range accesses return an error response without touching the RAM.

---
 rtl/mem_lsu_pkg.sv | 45 ++++
 rtl/lsu_align.sv | 46 ++++
 rtl/mem_lsu.sv | 125 ++++++++++++
 tb/tb_mem_lsu.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// Shared types and decode helpers for the load/store unit in front of the
// word-addressed data RAM.
package mem_lsu_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WRITE,
    S_RESP
  } lsu_state_e;

  // Only the fields still needed after the word index has been issued.
  typedef struct packed {
    logic        we;
    logic [2:0]  funct3;
    logic [1:0]  lane;
    logic [15:0] wdata;
  } lsu_req_t;

  function automatic logic is_misaligned(input logic [2:0] funct3,
                                         input logic [1:0] lo);
    case (funct3)
      F3_H, F3_HU: return lo[0];
      F3_W:        return lo != 2'b00;
      default:     return 1'b0;
    endcase
  endfunction

  // Unsigned sub-word stores do not exist.
  function automatic logic is_illegal_f3(input logic we,
                                         input logic [2:0] funct3);
    case (funct3)
      F3_B, F3_H, F3_W: return 1'b0;
      F3_BU, F3_HU:     return we;
      default:          return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering: load extraction/extension and store merge into the
// old word for read-modify-write of SB/SH.
module lsu_align
  import mem_lsu_pkg::*;
(
  input  logic [31:0] rd,
  input  logic [1:0]  lane,
  input  logic [2:0]  funct3,
  input  logic [15:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] st_word
);

  logic [3:0][7:0] rd_b;
  logic [3:0][7:0] st_b;
  logic [7:0]      b;
  logic [15:0]     h;

  assign rd_b = rd;
  assign b    = rd_b[lane];
  assign h    = lane[1] ? rd[31:16] : rd[15:0];

  always_comb begin
    ld_data = rd;
    case (funct3)
      F3_B:    ld_data = {{24{b[7]}}, b};
      F3_BU:   ld_data = {24'h0, b};
      F3_H:    ld_data = {{16{h[15]}}, h};
      F3_HU:   ld_data = {16'h0, h};
      default: ld_data = rd;
    endcase
  end

  // Little-endian: a half at lane[1] covers bytes {2*lane[1]+1, 2*lane[1]}.
  for (genvar i = 0; i < 4; i++) begin : g_lane
    localparam logic [1:0] L = 2'(i);
    logic hit;
    assign hit     = (funct3 == F3_B && lane == L) ||
                     (funct3 == F3_H && lane[1] == L[1]);
    assign st_b[i] = !hit ? rd_b[i]
                   : (funct3 == F3_H) ? wdata[8*(i%2) +: 8] : wdata[7:0];
  end

  assign st_word = st_b;

endmodule

// File: rtl/mem_lsu.sv
// Load/store unit: accepts byte-addressed requests, drives a 32-bit RAM with
// no byte enables (SB/SH via read-modify-write), and returns one response.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        ram_re,
  output logic        ram_we,
  output logic [31:0] ram_a,
  output logic [31:0] ram_wd,
  input  logic [31:0] ram_rd
);

  localparam logic [31:0] ADDR_LIMIT = 32'(4 * DEPTH_WORDS);

  lsu_state_e  state;
  lsu_req_t    req_q;
  logic        req_err;
  logic [31:0] ld_data;
  logic [31:0] st_word;

  assign req_err = is_illegal_f3(req_we, req_funct3) ||
                   is_misaligned(req_funct3, req_addr[1:0]) ||
                   (req_addr >= ADDR_LIMIT);

  lsu_align u_align (
    .rd      (ram_rd),
    .lane    (req_q.lane),
    .funct3  (req_q.funct3),
    .wdata   (req_q.wdata),
    .ld_data (ld_data),
    .st_word (st_word)
  );

  // RAM controls are registered on entry to each state, so an async reset
  // in WRITE drops ram_we before the edge that would commit the store.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      req_q      <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      ram_re     <= 1'b0;
      ram_we     <= 1'b0;
      ram_a      <= '0;
      ram_wd     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_q     <= '{we: req_we, funct3: req_funct3,
                           lane: req_addr[1:0], wdata: req_wdata[15:0]};
            req_ready <= 1'b0;
            if (req_err) begin
              state      <= S_RESP;
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
              resp_rdata <= '0;
            end else begin
              state <= S_ACCESS;
              ram_a <= {2'b00, req_addr[31:2]};
              if (req_we && req_funct3 == F3_W) begin
                ram_we <= 1'b1;
                ram_wd <= req_wdata;
              end else begin
                ram_re <= 1'b1;
              end
            end
          end
        end
        S_ACCESS: begin
          ram_re <= 1'b0;
          if (req_q.we && req_q.funct3 != F3_W) begin
            state  <= S_WRITE;
            ram_we <= 1'b1;
            ram_wd <= st_word;
          end else begin
            state      <= S_RESP;
            ram_we     <= 1'b0;
            ram_wd     <= '0;
            ram_a      <= '0;
            resp_valid <= 1'b1;
            resp_err   <= 1'b0;
            resp_rdata <= req_q.we ? 32'h0 : ld_data;
          end
        end
        S_WRITE: begin
          state      <= S_RESP;
          ram_we     <= 1'b0;
          ram_wd     <= '0;
          ram_a      <= '0;
          resp_valid <= 1'b1;
          resp_err   <= 1'b0;
          resp_rdata <= '0;
        end
        S_RESP: begin
          if (resp_ready) begin
            state      <= S_IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_err   <= 1'b0;
            resp_rdata <= '0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_lsu.sv
// Self-checking bench for mem_lsu: directed scenarios plus random traffic
// against an arithmetic memory model.
module tb_mem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'b0;
  logic [31:0] req_addr = 32'h0;
  logic [31:0] req_wdata = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        ram_re, ram_we;
  logic [31:0] ram_a, ram_wd, ram_rd;

  logic [31:0] mem     [1024];
  logic [31:0] ref_mem [1024];
  int          errors = 0;
  int          checks = 0;
  logic        both_seen = 1'b0;

  always #5 clk = ~clk;

  mem_lsu #(.DEPTH_WORDS(1024)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err),
    .ram_re(ram_re), .ram_we(ram_we), .ram_a(ram_a), .ram_wd(ram_wd),
    .ram_rd(ram_rd)
  );

  // Data RAM: combinational read, write on rising edge.
  assign ram_rd = ram_re ? mem[ram_a[9:0]] : 32'h0;
  always @(posedge clk) if (ram_we) mem[ram_a[9:0]] <= ram_wd;
  always @(negedge clk) if (ram_re && ram_we) both_seen <= 1'b1;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " req_ready"},  32'(req_ready),  32'd1);
    check({tag, " resp_valid"}, 32'(resp_valid), 32'd0);
    check({tag, " resp_rdata"}, resp_rdata,      32'd0);
    check({tag, " resp_err"},   32'(resp_err),   32'd0);
    check({tag, " ram_re"},     32'(ram_re),     32'd0);
    check({tag, " ram_we"},     32'(ram_we),     32'd0);
    check({tag, " ram_a"},      ram_a,           32'd0);
    check({tag, " ram_wd"},     ram_wd,          32'd0);
  endtask

  // Reference behaviour from the architectural rules, updating ref_mem.
  task automatic ref_model(input logic we, input logic [2:0] f3,
                           input logic [31:0] addr, input logic [31:0] wd,
                           output logic err, output logic [31:0] rd,
                           output int lat);
    logic [31:0] word, v, mask;
    int unsigned sh;
    err = (f3 == 3 || f3 == 6 || f3 == 7) || (we && f3 >= 4) ||
          ((f3 == 1 || f3 == 5) && addr % 2 != 0) ||
          (f3 == 2 && addr % 4 != 0) || (addr >= 4096);
    rd = 0;
    lat = 1;
    if (err) return;
    word = ref_mem[addr / 4];
    sh   = (addr % 4) * 8;
    if (!we) begin
      lat = 2;
      case (f3)
        3'd0: begin v = (word >> sh) % 256;   if (v >= 128)   v = v + 32'hFFFFFF00; end
        3'd4: v = (word >> sh) % 256;
        3'd1: begin v = (word >> sh) % 65536; if (v >= 32768) v = v + 32'hFFFF0000; end
        3'd5: v = (word >> sh) % 65536;
        default: v = word;
      endcase
      rd = v;
    end else if (f3 == 2) begin
      lat = 2;
      ref_mem[addr / 4] = wd;
    end else begin
      lat  = 3;
      mask = (f3 == 0) ? 32'd255 : 32'd65535;
      ref_mem[addr / 4] = (word & ~(mask << sh)) | ((wd & mask) << sh);
    end
  endtask

  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wd,
                        input int hold, output logic [31:0] got);
    logic        exp_err, touched;
    logic [31:0] exp_rd;
    int          exp_lat, lat;
    ref_model(we, f3, addr, wd, exp_err, exp_rd, exp_lat);
    @(negedge clk);
    check("req_ready before", 32'(req_ready), 32'd1);
    if (hold > 0) resp_ready = 1'b0;
    req_valid = 1'b1; req_we = we; req_funct3 = f3;
    req_addr = addr; req_wdata = wd;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    touched = ram_re | ram_we;
    while (!resp_valid && lat < 8) begin
      @(posedge clk); #1;
      lat++;
      touched |= ram_re | ram_we;
    end
    got = resp_rdata;
    check("resp_valid", 32'(resp_valid), 32'd1);
    check("latency", 32'(lat), 32'(exp_lat));
    check("resp_err", 32'(resp_err), 32'(exp_err));
    check("resp_rdata", resp_rdata, exp_rd);
    check("ram idle in resp", 32'(ram_re | ram_we), 32'd0);
    if (exp_err) check("ram untouched on err", 32'(touched), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h0;
      @(posedge clk); #1;
      check("hold resp_valid", 32'(resp_valid), 32'd1);
      check("hold resp_rdata", resp_rdata, exp_rd);
      check("hold req_ready", 32'(req_ready), 32'd0);
    end
    @(negedge clk);
    req_valid = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    check("resp done", 32'(resp_valid), 32'd0);
    check("ready again", 32'(req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] got;
    for (int i = 0; i < 1024; i++) begin
      mem[i] = $urandom;
      ref_mem[i] = mem[i];
    end
    mem[0] = 32'h1;  ref_mem[0] = 32'h1;
    mem[3] = 32'h16; ref_mem[3] = 32'h16;
    mem[7] = 32'h2E; ref_mem[7] = 32'h2E;

    #12;
    check_reset_outputs("reset");
    @(negedge clk); rst_n = 1'b1;

    do_req(1'b0, 3'd2, 32'h0C, 32'h0, 0, got);
    check("LW 0x0C", got, 32'h00000016);
    do_req(1'b0, 3'd4, 32'h1C, 32'h0, 0, got);
    check("LBU 0x1C", got, 32'h0000002E);
    do_req(1'b1, 3'd0, 32'h0D, 32'h80, 0, got);
    do_req(1'b0, 3'd2, 32'h0C, 32'h0, 0, got);
    check("SB word3", got, 32'h00008016);
    do_req(1'b0, 3'd0, 32'h0D, 32'h0, 0, got);
    check("LB 0x0D", got, 32'hFFFFFF80);
    do_req(1'b0, 3'd4, 32'h0D, 32'h0, 0, got);
    check("LBU 0x0D", got, 32'h00000080);
    do_req(1'b0, 3'd1, 32'h0C, 32'h0, 0, got);
    check("LH 0x0C", got, 32'hFFFF8016);
    do_req(1'b1, 3'd1, 32'h1E, 32'h1234ABCD, 0, got);
    do_req(1'b0, 3'd2, 32'h1C, 32'h0, 0, got);
    check("SH word7", got, 32'hABCD002E);
    do_req(1'b1, 3'd2, 32'h20, 32'hCAFEF00D, 0, got);
    do_req(1'b0, 3'd5, 32'h22, 32'h0, 0, got);
    check("LHU after SW", got, 32'h0000CAFE);

    do_req(1'b0, 3'd2, 32'h0E,   32'h0, 0, got);
    do_req(1'b1, 3'd1, 32'h0D,   32'h0, 0, got);
    do_req(1'b0, 3'd2, 32'h1000, 32'h0, 0, got);
    do_req(1'b1, 3'd4, 32'h10,   32'h0, 0, got);
    do_req(1'b0, 3'd3, 32'h10,   32'h0, 0, got);

    do_req(1'b0, 3'd2, 32'h0C, 32'h0, 3, got);
    check("held LW", got, 32'h00008016);

    // Reset while SB 0xFF to addr 0 sits in WRITE.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd0;
    req_addr = 32'h0; req_wdata = 32'hFF;
    @(posedge clk); #1 req_valid = 1'b0;
    @(posedge clk); #2;
    check("in WRITE ram_we", 32'(ram_we), 32'd1);
    rst_n = 1'b0;
    #1 check_reset_outputs("mid reset");
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    #1 check("post reset req_ready", 32'(req_ready), 32'd1);
    do_req(1'b0, 3'd2, 32'h0, 32'h0, 0, got);
    check("word0 intact", got, 32'h00000001);

    for (int n = 0; n < 60; n++) begin
      logic [31:0] a;
      a = ($urandom % 10 == 0) ? 32'h1000 + ($urandom % 64) : $urandom % 128;
      do_req(1'($urandom), 3'($urandom), a, $urandom,
             ($urandom % 8 == 0) ? 2 : 0, got);
    end

    check("re and we never both", 32'(both_seen), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #400000;
    errors++;
    $display("FAIL timeout: simulation did not finish");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
